// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the intersection controller blocks
//                (padestrain_system, traffic_control, counter): the phase
//                encoding, default tick constants and small phase helpers.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // Phase encoding is observable on the pedestrian block's phase port.
    typedef enum logic [1:0] {
        MAIN_WALK   = 2'd0,
        MAIN_CLEAR  = 2'd1,
        LOCAL_WALK  = 2'd2,
        LOCAL_CLEAR = 2'd3
    } phase_e;

    localparam int C_WALK_TICKS  = 8;
    localparam int C_FLASH_TICKS = 3;
    localparam int C_CLEAR_TICKS = 2;
    localparam int C_CNT_W       = 4;

    // Cycle order: LOCAL_CLEAR -> MAIN_WALK -> MAIN_CLEAR -> LOCAL_WALK -> ...
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            MAIN_WALK:  return MAIN_CLEAR;
            MAIN_CLEAR: return LOCAL_WALK;
            LOCAL_WALK: return LOCAL_CLEAR;
            default:    return MAIN_WALK;
        endcase
    endfunction

    function automatic logic is_walk(input phase_e p);
        return (p == MAIN_WALK) || (p == LOCAL_WALK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ped_phase_timer
//  Description : Phase and tick-count registers for the pedestrian sequencer.
//                Each enable tick either increments the count or, on the
//                terminal tick of the current phase, advances the phase and
//                clears the count.
//  Ports       : clk       - clock
//                rst_a     - synchronous active-high reset (-> LOCAL_CLEAR, 0)
//                enable_i  - tick strobe
//                phase_o   - current phase (traffic_pkg::phase_e encoding)
//                cnt_o     - tick count within the current phase
//  Revision    : 1.0  initial release
// ============================================================================
module ped_phase_timer
    import traffic_pkg::*;
#(
    parameter int WALK_TICKS  = C_WALK_TICKS,
    parameter int CLEAR_TICKS = C_CLEAR_TICKS,
    parameter int CNT_W       = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             enable_i,
    output logic [1:0]       phase_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] C_WALK_LAST  = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] C_CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);

    phase_e           phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_w;
    logic             terminal_w;

    // '>=' rather than '==' so any count beyond the phase length (not
    // reachable in normal operation) advances on the next tick.
    always_comb begin
        last_w     = is_walk(phase_q) ? C_WALK_LAST : C_CLEAR_LAST;
        terminal_w = (cnt_q >= last_w);
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            phase_q <= LOCAL_CLEAR;
            cnt_q   <= '0;
        end else if (enable_i) begin
            if (terminal_w) begin
                phase_q <= next_phase(phase_q);
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign phase_o = phase_q;
    assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/padestrain_system.sv
`default_nettype none
// ============================================================================
//  Module      : padestrain_system
//  Description : Pedestrian-signal sequencer for a four-way intersection.
//                Steps through walk/clear phases on enable_P ticks and drives
//                one WALK bit per crosswalk, flashing during the tail of each
//                walk phase.
//  Ports       : clk                   - clock
//                rst_a                 - synchronous active-high reset
//                enable_P              - phase-timing strobe
//                Main_North_Padestrain - WALK, north crosswalk
//                Main_South_Padestrain - WALK, south crosswalk
//                Local_East_Padestrain - WALK, east crosswalk
//                Local_West_Padestrain - WALK, west crosswalk
//                phase                 - current phase (0..3)
//  Revision    : 1.0  initial release
// ============================================================================
module padestrain_system
    import traffic_pkg::*;
#(
    parameter int WALK_TICKS  = C_WALK_TICKS,
    parameter int FLASH_TICKS = C_FLASH_TICKS,
    parameter int CLEAR_TICKS = C_CLEAR_TICKS,
    parameter int CNT_W       = C_CNT_W
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       enable_P,
    output logic       Main_North_Padestrain,
    output logic       Main_South_Padestrain,
    output logic       Local_East_Padestrain,
    output logic       Local_West_Padestrain,
    output logic [1:0] phase
);

    localparam int C_MAX_TICKS = (WALK_TICKS > CLEAR_TICKS) ? WALK_TICKS : CLEAR_TICKS;

    if (FLASH_TICKS < 0 || FLASH_TICKS >= WALK_TICKS) begin : g_bad_flash
        $error("padestrain_system: FLASH_TICKS must be in [0, WALK_TICKS)");
    end
    if (CLEAR_TICKS < 1) begin : g_bad_clear
        $error("padestrain_system: CLEAR_TICKS must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 30 || (C_MAX_TICKS - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("padestrain_system: CNT_W too small for the longest phase");
    end

    // One extra bit so WALK_TICKS == 2**CNT_W with no flash still compares right.
    localparam logic [CNT_W:0] C_STEADY = (CNT_W + 1)'(WALK_TICKS - FLASH_TICKS);

    logic [1:0]       phase_w;
    logic [CNT_W-1:0] cnt_w;
    logic             walk_w;
    logic             ns_w;
    logic             ew_w;

    ped_phase_timer #(
        .WALK_TICKS  (WALK_TICKS),
        .CLEAR_TICKS (CLEAR_TICKS),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_a    (rst_a),
        .enable_i (enable_P),
        .phase_o  (phase_w),
        .cnt_o    (cnt_w)
    );

    // Flash window: k = cnt - STEADY, lit on odd k, so the first flash tick is
    // dark. Parity of k is just the XOR of the two LSBs.
    always_comb begin
        walk_w = ({1'b0, cnt_w} < C_STEADY) ? 1'b1 : (cnt_w[0] ^ C_STEADY[0]);
        ns_w   = (phase_w == MAIN_WALK)  && walk_w;
        ew_w   = (phase_w == LOCAL_WALK) && walk_w;
    end

    assign Main_North_Padestrain = ns_w;
    assign Main_South_Padestrain = ns_w;
    assign Local_East_Padestrain = ew_w;
    assign Local_West_Padestrain = ew_w;
    assign phase                 = phase_w;

endmodule
`default_nettype wire

// File: tb/tb_padestrain_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_padestrain_system
//  Description : Scoreboard bench for padestrain_system. Drives the default
//                configuration and a short variant (WALK 4, FLASH 0, CLEAR 1)
//                from the same stimulus and compares both against a
//                behavioural model of the phase schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_padestrain_system;

    typedef struct packed {
        logic [1:0] ph;
        logic       n;
        logic       s;
        logic       e;
        logic       w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       enable_P = 1'b0;
    logic [1:0] n_o, s_o, e_o, w_o;
    logic [1:0] ph_o [2];

    int checks = 0;
    int fails  = 0;

    // Model configuration per instance: 0 = defaults, 1 = variant.
    int m_walk  [2] = '{8, 4};
    int m_flash [2] = '{3, 0};
    int m_clear [2] = '{2, 1};
    int m_ph    [2] = '{3, 3};
    int m_cnt   [2] = '{0, 0};

    exp_t sb_q [2][$];

    always #5 clk = ~clk;

    padestrain_system u_dut (
        .clk                   (clk),
        .rst_a                 (rst_a),
        .enable_P              (enable_P),
        .Main_North_Padestrain (n_o[0]),
        .Main_South_Padestrain (s_o[0]),
        .Local_East_Padestrain (e_o[0]),
        .Local_West_Padestrain (w_o[0]),
        .phase                 (ph_o[0])
    );

    padestrain_system #(
        .WALK_TICKS  (4),
        .FLASH_TICKS (0),
        .CLEAR_TICKS (1),
        .CNT_W       (2)
    ) u_var (
        .clk                   (clk),
        .rst_a                 (rst_a),
        .enable_P              (enable_P),
        .Main_North_Padestrain (n_o[1]),
        .Main_South_Padestrain (s_o[1]),
        .Local_East_Padestrain (e_o[1]),
        .Local_West_Padestrain (w_o[1]),
        .phase                 (ph_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Spec-level model: phases run 3,0,1,2,3,... ; even phases are walks.
    function automatic exp_t model_out(input int i);
        exp_t r;
        int   steady;
        logic wv;
        steady = m_walk[i] - m_flash[i];
        if (m_cnt[i] < steady) wv = 1'b1;
        else                   wv = ((m_cnt[i] - steady) % 2) == 1;
        r.ph = 2'(m_ph[i]);
        r.n  = (m_ph[i] == 0) && wv;
        r.s  = r.n;
        r.e  = (m_ph[i] == 2) && wv;
        r.w  = r.e;
        return r;
    endfunction

    task automatic step(input bit en, input bit rs);
        int dur;
        @(negedge clk);
        enable_P = en;
        rst_a    = rs;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                m_ph[i]  = 3;
                m_cnt[i] = 0;
            end else if (en) begin
                dur = (m_ph[i] % 2 == 0) ? m_walk[i] : m_clear[i];
                if (m_cnt[i] == dur - 1) begin
                    m_ph[i]  = (m_ph[i] + 1) % 4;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            sb_q[i].push_back(model_out(i));
        end
    endtask

    // Sample just after the edge the expectation belongs to.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock each instance presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (sb_q[i].size() > 0) begin
                    e = sb_q[i].pop_front();
                    chk($sformatf("phase[%0d]", i), int'(ph_o[i]), int'(e.ph));
                    chk($sformatf("nsew[%0d]", i),
                        int'({n_o[i], s_o[i], e_o[i], w_o[i]}),
                        int'({e.n, e.s, e.e, e.w}));
                    chk($sformatf("no_conflict[%0d]", i),
                        int'((n_o[i] | s_o[i]) & (e_o[i] | w_o[i])), 0);
                end
            end
        end
    end

    initial begin
        // Reset held three clocks while enable_P toggles.
        step(1, 1);
        step(0, 1);
        step(1, 1);
        after_edge();
        chk("reset_phase", int'(ph_o[0]), 3);
        chk("reset_walk", int'({n_o[0], s_o[0], e_o[0], w_o[0]}), 0);
        // Release with no ticks: must hold.
        repeat (3) step(0, 0);
        after_edge();
        chk("hold_phase", int'(ph_o[0]), 3);

        // Startup: one pulse every 4 clocks, a full default cycle and more.
        step(1, 0); repeat (3) step(0, 0);
        step(1, 0);
        after_edge();
        chk("startup_phase", int'(ph_o[0]), 0);
        chk("startup_ns", int'({n_o[0], s_o[0], e_o[0], w_o[0]}), 4'b1100);
        repeat (3) step(0, 0);
        repeat (22) begin
            step(1, 0);
            repeat (3) step(0, 0);
        end

        // Continuous strobe from a fresh LOCAL_CLEAR entry: both configs
        // are in LOCAL_WALK after 19 ticks and back in LOCAL_CLEAR after 20.
        step(0, 1);
        repeat (19) step(1, 0);
        after_edge();
        chk("cont19_def", int'(ph_o[0]), 2);
        chk("cont19_var", int'(ph_o[1]), 2);
        step(1, 0);
        after_edge();
        chk("cont20_def", int'(ph_o[0]), 3);
        chk("cont20_var", int'(ph_o[1]), 3);

        // Mid-op reset at LOCAL_WALK count 3 (15 ticks after reset).
        step(0, 1);
        repeat (15) step(1, 0);
        after_edge();
        chk("midop_pre_phase", int'(ph_o[0]), 2);
        step(1, 1);
        after_edge();
        chk("midop_rst_phase", int'(ph_o[0]), 3);
        chk("midop_rst_walk", int'({n_o[0], s_o[0], e_o[0], w_o[0]}), 0);
        step(1, 0);
        after_edge();
        chk("midop_1tick", int'(ph_o[0]), 3);
        step(1, 0);
        after_edge();
        chk("midop_2tick", int'(ph_o[0]), 0);

        // Random strobe density with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            bit en;
            bit rs;
            case ((k / 300) % 3)
                0:       en = ($urandom_range(3, 0) == 0);
                1:       en = ($urandom_range(1, 0) == 1);
                default: en = ($urandom_range(7, 0) != 0);
            endcase
            rs = ($urandom_range(79, 0) == 0);
            step(en, rs);
        end

        step(0, 0);
        after_edge();
        after_edge();
        chk("sb_drained0", sb_q[0].size(), 0);
        chk("sb_drained1", sb_q[1].size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/padestrain_system.md
Name: padestrain_system

Overview:
Pedestrian-signal sequencer for a four-way intersection: main street (North/South) and local street (East/West). It advances through walk/clear phases on strobes from the shared timing counter (`counter` block, `enable_P` output). It runs alongside `traffic_control`, which sequences the vehicle lights from `enable_L`. It drives one WALK bit per crosswalk and exposes its current phase for observation.

Parameters:
WALK_TICKS, 8, enable_P ticks spent in each walk phase (flash window included); must be > FLASH_TICKS
FLASH_TICKS, 3, trailing ticks of each walk phase during which WALK flashes; 0 disables flashing
CLEAR_TICKS, 2, enable_P ticks in each all-stop clearance phase; must be >= 1
CNT_W, 4, tick-counter width; must hold max(WALK_TICKS, CLEAR_TICKS)-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_a  input  1  synchronous, active-high reset
enable_P  input  1  phase-timing strobe; each clock it is sampled high counts as one tick
Main_North_Padestrain  output  1  1 = WALK on north crosswalk
Main_South_Padestrain  output  1  1 = WALK on south crosswalk
Local_East_Padestrain  output  1  1 = WALK on east crosswalk
Local_West_Padestrain  output  1  1 = WALK on west crosswalk
phase  output  2  current phase: 0 MAIN_WALK, 1 MAIN_CLEAR, 2 LOCAL_WALK, 3 LOCAL_CLEAR

Behaviour:
- Interface: one clock (clk); reset rst_a is synchronous and active-high.
- State: registered phase (2 bits) and tick count (CNT_W bits). Outputs are a pure decode of these registers, so they change one clk edge after enable_P is sampled high.
- Reset: rst_a high at a clk edge sets phase = LOCAL_CLEAR and count = 0, so all four WALK outputs are 0 and phase = 3. Reset overrides enable_P. Reset mid-phase takes effect at that edge, with no partial completion.
- Phase cycle: LOCAL_CLEAR → MAIN_WALK → MAIN_CLEAR → LOCAL_WALK → LOCAL_CLEAR → …
- Phase durations: CLEAR phases last CLEAR_TICKS ticks; WALK phases last WALK_TICKS ticks.
- Tick handling, on an edge with enable_P = 1 and rst_a = 0:
  - if count == duration(phase) - 1: advance phase and set count to 0;
  - else: increment count.
- enable_P = 0: state holds. enable_P held high: advances every clock.
- Output decode:
  - MAIN_WALK: North = South = W; East = West = 0.
  - LOCAL_WALK: East = West = W; North = South = 0.
  - CLEAR phases: all 0.
- W (walk value) for count c:
  - c < WALK_TICKS - FLASH_TICKS: W = 1 (steady WALK);
  - otherwise, with k = c - (WALK_TICKS - FLASH_TICKS): W = 1 when k is odd, 0 when k is even (flash starts dark).
- Invariants:
  - N/S WALK and E/W WALK are never 1 simultaneously.
  - North always equals South; East always equals West.
  - Every walk phase is preceded and followed by a clear phase of at least one tick.
- Counter never wraps: phase change resets it before CNT_W overflow. Any unreachable count value forces an advance on the next tick.
- Illegal parameter sets (FLASH_TICKS >= WALK_TICKS, CLEAR_TICKS = 0, CNT_W too small) are rejected by elaboration-time assertion.
- Full cycle length = 2*(WALK_TICKS + CLEAR_TICKS) ticks (20 with defaults).

Decomposition:
- Shared package `traffic_pkg`:
  - phase enum (MAIN_WALK = 0, MAIN_CLEAR = 1, LOCAL_WALK = 2, LOCAL_CLEAR = 3);
  - default tick constants, shared with traffic_control and counter.
- One sub-module `ped_phase_timer`:
  - holds phase/count registers and advance logic, with a terminal-tick compare;
  - padestrain_system keeps the output decode and flash logic.

Test Plan:
- Reset: rst_a high 3 clocks while enable_P toggles → all WALK = 0, phase = 3, state unchanged; release with enable_P = 0 → holds at phase 3.
- Startup: after reset, one enable_P pulse every 4 clocks → after 2nd pulse, phase = 0, N = S = 1, E = W = 0 on the edge after the pulse.
- Flash and clear (defaults): MAIN_WALK ticks 0-4 → N/S = 1; ticks 5, 6, 7 → 0, 1, 0; next pulse → phase = 1, all 0; 2 more pulses → phase = 2, E = W = 1.
- Continuous strobe: enable_P tied high → phase returns to 3 exactly 20 clocks after entering it; N/S and E/W never both 1 (assertion checked every cycle).
- Mid-op reset: assert rst_a at LOCAL_WALK count 3 → next edge all 0, phase = 3, count 0; afterwards 2 pulses are required to reach MAIN_WALK.
- Parameter variant FLASH_TICKS = 0, WALK_TICKS = 4, CLEAR_TICKS = 1 → walk steady 1 for 4 ticks; full cycle = 10 ticks.
